// File: rtl/fw_ip2_pkg.sv
// Shared types and constants for the fw_ip2 configuration-chain serializer.
package fw_ip2_pkg;

  localparam int CFG_WORD_W = 24;
  localparam int CFG_BIT_W  = $clog2(CFG_WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } cfg_ser_state_t;

  localparam int STAT_BUSY_BIT        = 0;
  localparam int STAT_DONE_SEEN_BIT   = 1;
  localparam int STAT_ERR_WR_BUSY_BIT = 2;

  // Packs serializer status into the fw_read_status32 word layout.
  function automatic logic [31:0] cfg_ser_status(input logic busy,
                                                 input logic done_seen,
                                                 input logic err_wr_busy);
    logic [31:0] s;
    s                       = '0;
    s[STAT_BUSY_BIT]        = busy;
    s[STAT_DONE_SEEN_BIT]   = done_seen;
    s[STAT_ERR_WR_BUSY_BIT] = err_wr_busy;
    return s;
  endfunction

endpackage

// File: rtl/fw_ip2_cfg_serializer_if.sv
// SW-side register bus of the config-chain serializer (write/read/execute/status).
interface fw_ip2_cfg_serializer_if;
  import fw_ip2_pkg::*;

  logic                  wr_en;
  logic [CFG_WORD_W-1:0] wr_data;
  logic                  rd_en;
  logic [CFG_WORD_W-1:0] rd_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  err_wr_busy;

  modport master (
    output wr_en, wr_data, rd_en, start,
    input  rd_data, busy, done, err_wr_busy
  );

  modport slave (
    input  wr_en, wr_data, rd_en, start,
    output rd_data, busy, done, err_wr_busy
  );

endinterface

// File: rtl/fw_ip2_cfg_word_buf.sv
// NUM_WORDS x 24-bit register file: word write port, single-bit capture port, word read port.
module fw_ip2_cfg_word_buf
  import fw_ip2_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [CFG_WORD_W-1:0] wr_data,
  input  logic                  cap_en,
  input  logic [ADDR_W-1:0]     cap_word,
  input  logic [CFG_BIT_W-1:0]  cap_bit,
  input  logic                  cap_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [CFG_WORD_W-1:0] rd_word
);

  logic [CFG_WORD_W-1:0] mem_q [NUM_WORDS];
  logic [CFG_WORD_W-1:0] mem_d [NUM_WORDS];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_d[i] = '0;
    end else begin
      if (wr_en)  mem_d[wr_addr] = wr_data;
      if (cap_en) mem_d[cap_word][cap_bit] = cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_word = mem_q[rd_addr];

endmodule

// File: rtl/fw_ip2_cfg_serializer.sv
// Buffers SW config words, shifts them MSB-first into the DUT config chain, captures the
// returning chain bits for SW readback, then strobes the chain parallel load.
module fw_ip2_cfg_serializer
  import fw_ip2_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic                    fw_clk,
  input  logic                    fw_rst_n,
  input  logic                    sw_reset,
  fw_ip2_cfg_serializer_if.slave  sw,
  output logic                    fw_config_clk,
  output logic                    fw_config_in,
  output logic                    fw_config_load,
  input  logic                    fw_config_out
);

  localparam int CHAIN_BITS = NUM_WORDS * CFG_WORD_W;
  localparam int PTR_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int DIV_W      = $clog2(CLK_DIV + 1);
  localparam int BIT_W      = $clog2(CHAIN_BITS + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_WORDS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_BITS - 1);

  // Shift index k goes out first-to-last; chain position is CHAIN_BITS-1-k.
  function automatic logic [PTR_W-1:0] pos_word(input logic [BIT_W-1:0] k);
    int p;
    p = CHAIN_BITS - 1 - int'(k);
    return PTR_W'(p / CFG_WORD_W);
  endfunction

  function automatic logic [CFG_BIT_W-1:0] pos_bit(input logic [BIT_W-1:0] k);
    int p;
    p = CHAIN_BITS - 1 - int'(k);
    return CFG_BIT_W'(p % CFG_WORD_W);
  endfunction

  cfg_ser_state_t        state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  load_half_q, load_half_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CFG_WORD_W-1:0] rd_data_q, rd_data_d;
  logic                  cfg_in_q, cfg_in_d;
  logic                  err_q, err_d;

  logic                  busy_st;
  logic                  wr_accept;
  logic                  cap_en;
  logic [BIT_W-1:0]      tx_k;
  logic [PTR_W-1:0]      tx_addr;
  logic [CFG_WORD_W-1:0] tx_rd_word;
  logic [CFG_WORD_W-1:0] tx_word;
  logic                  tx_bit;
  logic [CFG_WORD_W-1:0] cap_rd_word;

  assign busy_st   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
  assign wr_accept = (state_q == IDLE) && sw.wr_en && !sw_reset;

  // Next bit to present: index 0 when starting from IDLE, otherwise the following bit.
  assign tx_k    = (state_q == IDLE) ? '0 : bit_q + BIT_W'(1);
  assign tx_addr = pos_word(tx_k);
  // A write landing in the same cycle as start must be visible to the first shifted bit.
  assign tx_word = (wr_accept && (wr_ptr_q == tx_addr)) ? sw.wr_data : tx_rd_word;
  assign tx_bit  = tx_word[pos_bit(tx_k)];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    load_half_d = load_half_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    cfg_in_d    = cfg_in_q;
    err_d       = err_q;
    cap_en      = 1'b0;

    if (wr_accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (busy_st && (sw.wr_en || sw.start)) err_d = 1'b1;
    if (sw.rd_en) begin
      rd_data_d = cap_rd_word;
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (sw.start) begin
          state_d  = SHIFT_LO;
          div_d    = '0;
          bit_d    = '0;
          cfg_in_d = tx_bit;
        end
      end
      SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          div_d   = '0;
          cap_en  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d     = LOAD;
            load_half_d = 1'b0;
          end else begin
            state_d  = SHIFT_LO;
            bit_d    = tx_k;
            cfg_in_d = tx_bit;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LOAD: begin
        // Load lasts two divider periods; load_half marks the second one.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (load_half_q) state_d = DONE;
          else             load_half_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sw_reset) begin
      state_d     = IDLE;
      div_d       = '0;
      bit_d       = '0;
      load_half_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rd_data_d   = '0;
      cfg_in_d    = 1'b0;
      err_d       = 1'b0;
      cap_en      = 1'b0;
    end
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      load_half_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      cfg_in_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      load_half_q <= load_half_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      cfg_in_q    <= cfg_in_d;
      err_q       <= err_d;
    end
  end

  fw_ip2_cfg_word_buf #(.NUM_WORDS(NUM_WORDS), .ADDR_W(PTR_W)) u_tx_buf (
    .clk      (fw_clk),
    .rst_n    (fw_rst_n),
    .clr      (sw_reset),
    .wr_en    (wr_accept),
    .wr_addr  (wr_ptr_q),
    .wr_data  (sw.wr_data),
    .cap_en   (1'b0),
    .cap_word ('0),
    .cap_bit  ('0),
    .cap_data (1'b0),
    .rd_addr  (tx_addr),
    .rd_word  (tx_rd_word)
  );

  fw_ip2_cfg_word_buf #(.NUM_WORDS(NUM_WORDS), .ADDR_W(PTR_W)) u_cap_buf (
    .clk      (fw_clk),
    .rst_n    (fw_rst_n),
    .clr      (sw_reset),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_data  ('0),
    .cap_en   (cap_en),
    .cap_word (pos_word(bit_q)),
    .cap_bit  (pos_bit(bit_q)),
    .cap_data (fw_config_out),
    .rd_addr  (rd_ptr_q),
    .rd_word  (cap_rd_word)
  );

  assign fw_config_clk   = (state_q == SHIFT_HI);
  assign fw_config_load  = (state_q == LOAD);
  assign fw_config_in    = cfg_in_q;
  assign sw.busy         = busy_st;
  assign sw.done         = (state_q == DONE);
  assign sw.err_wr_busy  = err_q;
  assign sw.rd_data      = rd_data_q;

endmodule

// File: tb/tb_fw_ip2_cfg_serializer.sv
// Directed bench: two serializers (CLK_DIV=2 and CLK_DIV=1, two words each) with chain loopback models.
module tb_fw_ip2_cfg_serializer;
  import fw_ip2_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_reset;
  logic cfg_clk0, cfg_in0, cfg_load0, cfg_out0;
  logic cfg_clk1, cfg_in1, cfg_load1, cfg_out1;

  int checks = 0;
  int errors = 0;

  fw_ip2_cfg_serializer_if if0 ();
  fw_ip2_cfg_serializer_if if1 ();

  fw_ip2_cfg_serializer #(.NUM_WORDS(2), .CLK_DIV(2)) dut0 (
    .fw_clk(clk), .fw_rst_n(rst_n), .sw_reset(sw_reset), .sw(if0.slave),
    .fw_config_clk(cfg_clk0), .fw_config_in(cfg_in0),
    .fw_config_load(cfg_load0), .fw_config_out(cfg_out0)
  );

  fw_ip2_cfg_serializer #(.NUM_WORDS(2), .CLK_DIV(1)) dut1 (
    .fw_clk(clk), .fw_rst_n(rst_n), .sw_reset(sw_reset), .sw(if1.slave),
    .fw_config_clk(cfg_clk1), .fw_config_in(cfg_in1),
    .fw_config_load(cfg_load1), .fw_config_out(cfg_out1)
  );

  always #5 clk = ~clk;

  // 48-bit chain models: shift on config_clk rise, serial return from the MSB.
  logic [47:0] chain0, chain1, pre0, pre1;
  logic        ld0 = 1'b0, ld1 = 1'b0;
  int          edges0 = 0, edges1 = 0;

  always @(posedge cfg_clk0 or posedge ld0) begin
    if (ld0) chain0 <= pre0;
    else     chain0 <= {chain0[46:0], cfg_in0};
  end
  always @(posedge cfg_clk1 or posedge ld1) begin
    if (ld1) chain1 <= pre1;
    else     chain1 <= {chain1[46:0], cfg_in1};
  end
  always @(posedge cfg_clk0) edges0 <= edges0 + 1;
  always @(posedge cfg_clk1) edges1 <= edges1 + 1;
  assign cfg_out0 = chain0[47];
  assign cfg_out1 = chain1[47];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload0(input logic [47:0] v);
    pre0 = v; ld0 = 1'b1; #1; ld0 = 1'b0;
  endtask

  task automatic preload1(input logic [47:0] v);
    pre1 = v; ld1 = 1'b1; #1; ld1 = 1'b0;
  endtask

  task automatic write0(input logic [23:0] d);
    if0.wr_en = 1'b1; if0.wr_data = d; tick(); if0.wr_en = 1'b0;
  endtask

  task automatic write1(input logic [23:0] d);
    if1.wr_en = 1'b1; if1.wr_data = d; tick(); if1.wr_en = 1'b0;
  endtask

  task automatic start0();
    if0.start = 1'b1; tick(); if0.start = 1'b0;
  endtask

  task automatic pulse_sw_reset();
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
  endtask

  // Advances until the selected DUT shows done (bounded); counts load-high cycles on the way.
  task automatic run_done(input bit sel, inout int cyc, output int loads);
    loads = 0;
    while (((sel ? if1.done : if0.done) !== 1'b1) && cyc < 1000) begin
      if ((sel ? cfg_load1 : cfg_load0) === 1'b1) loads++;
      tick();
      cyc++;
    end
  endtask

  function automatic logic [29:0] outs0();
    return {if0.busy, if0.done, if0.err_wr_busy, cfg_clk0, cfg_in0, cfg_load0, if0.rd_data};
  endfunction

  initial begin
    int cyc, loads, e0, e1, seen, w;

    rst_n = 1'b0; sw_reset = 1'b0;
    if0.wr_en = 1'b0; if0.wr_data = '0; if0.rd_en = 1'b0; if0.start = 1'b0;
    if1.wr_en = 1'b0; if1.wr_data = '0; if1.rd_en = 1'b0; if1.start = 1'b0;
    preload0('0); preload1('0);
    tick(); tick();
    chk("reset_outs", 64'(outs0()), 64'h0);
    chk("reset_state", 64'(dut0.state_q), 64'(IDLE));
    rst_n = 1'b1;
    tick();

    // Basic shift with loopback
    write0(24'hA5A5A5);
    write0(24'h00000F);
    e0 = edges0;
    start0();
    cyc = 1;
    chk("first_bit", 64'(cfg_in0), 64'h0);
    chk("busy_after_start", 64'(if0.busy), 64'h1);
    run_done(1'b0, cyc, loads);
    chk("done_cycle", 64'(cyc), 64'd197);
    chk("load_cycles", 64'(loads), 64'd4);
    chk("clk_edges", 64'(edges0 - e0), 64'd48);
    chk("chain_basic", 64'(chain0), 64'({24'h00000F, 24'hA5A5A5}));
    chk("busy_at_done", 64'(if0.busy), 64'h0);
    tick();
    chk("done_one_cycle", 64'(if0.done), 64'h0);

    // Write and start in the same idle cycle
    pulse_sw_reset();
    write0(24'h3C3C3C);
    if0.wr_en = 1'b1; if0.wr_data = 24'h800001; if0.start = 1'b1;
    tick();
    if0.wr_en = 1'b0; if0.start = 1'b0;
    cyc = 1;
    chk("fwd_first_bit", 64'(cfg_in0), 64'h1);
    run_done(1'b0, cyc, loads);
    chk("fwd_chain", 64'(chain0), 64'({24'h800001, 24'h3C3C3C}));
    tick();

    // Capture readback
    pulse_sw_reset();
    preload0(48'h123456_789ABC);
    start0();
    cyc = 1;
    run_done(1'b0, cyc, loads);
    chk("cap_chain_zeroed", 64'(chain0), 64'h0);
    tick();
    if0.rd_en = 1'b1; tick(); if0.rd_en = 1'b0;
    chk("read_word0", 64'(if0.rd_data), 64'h789ABC);
    if0.rd_en = 1'b1; tick(); if0.rd_en = 1'b0;
    chk("read_word1", 64'(if0.rd_data), 64'h123456);

    // Write pointer wrap
    pulse_sw_reset();
    write0(24'h111111);
    write0(24'h222222);
    write0(24'h333333);
    chk("wr_ptr_wrap", 64'(dut0.wr_ptr_q), 64'h1);
    start0();
    cyc = 1;
    run_done(1'b0, cyc, loads);
    chk("wrap_chain", 64'(chain0), 64'({24'h222222, 24'h333333}));
    tick();

    // Write and start while busy are dropped
    start0();
    cyc = 1;
    while (cyc < 20) begin tick(); cyc++; end
    if0.wr_en = 1'b1; if0.wr_data = 24'hFFFFFF; if0.start = 1'b1;
    tick(); cyc++;
    if0.wr_en = 1'b0; if0.start = 1'b0;
    chk("err_wr_busy_set", 64'(if0.err_wr_busy), 64'h1);
    run_done(1'b0, cyc, loads);
    chk("busy_done_cycle", 64'(cyc), 64'd197);
    chk("busy_chain_unchanged", 64'(chain0), 64'({24'h222222, 24'h333333}));
    tick();
    pulse_sw_reset();
    chk("err_cleared", 64'(if0.err_wr_busy), 64'h0);

    // sw_reset mid-shift
    write0(24'hABCDEF);
    write0(24'h123456);
    preload0(48'hFFFF_FFFF_FFFF);
    start0();
    repeat (50) tick();
    sw_reset = 1'b1; tick(); sw_reset = 1'b0;
    chk("swrst_outs", 64'(outs0()), 64'h0);
    chk("swrst_state", 64'(dut0.state_q), 64'(IDLE));
    chk("swrst_tx", 64'({dut0.u_tx_buf.mem_q[1], dut0.u_tx_buf.mem_q[0]}), 64'h0);
    chk("swrst_cap", 64'({dut0.u_cap_buf.mem_q[1], dut0.u_cap_buf.mem_q[0]}), 64'h0);
    seen = 0;
    repeat (250) begin tick(); if (if0.done === 1'b1) seen++; end
    chk("swrst_no_done", 64'(seen), 64'h0);

    // Async reset while config_clk is high
    write0(24'h5A5A5A);
    write0(24'hC3C3C3);
    start0();
    w = 0;
    while (cfg_clk0 !== 1'b1 && w < 100) begin tick(); w++; end
    chk("reach_shift_hi", 64'(cfg_clk0), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 64'(outs0()), 64'h0);
    chk("arst_state", 64'(dut0.state_q), 64'(IDLE));
    chk("arst_tx", 64'({dut0.u_tx_buf.mem_q[1], dut0.u_tx_buf.mem_q[0]}), 64'h0);
    chk("arst_cap", 64'({dut0.u_cap_buf.mem_q[1], dut0.u_cap_buf.mem_q[0]}), 64'h0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (250) begin tick(); if (if0.done === 1'b1) seen++; end
    chk("arst_no_done", 64'(seen), 64'h0);

    // CLK_DIV=1 instance
    write1(24'h00FF00);
    write1(24'hF0000F);
    preload1('0);
    e1 = edges1;
    if1.start = 1'b1; tick(); if1.start = 1'b0;
    cyc = 1;
    chk("div1_first_bit", 64'(cfg_in1), 64'h1);
    chk("div1_clk_lo", 64'(cfg_clk1), 64'h0);
    tick(); cyc++;
    chk("div1_clk_hi", 64'(cfg_clk1), 64'h1);
    run_done(1'b1, cyc, loads);
    chk("div1_done_cycle", 64'(cyc), 64'd99);
    chk("div1_load_cycles", 64'(loads), 64'd2);
    chk("div1_clk_edges", 64'(edges1 - e1), 64'd48);
    chk("div1_chain", 64'(chain1), 64'({24'hF0000F, 24'h00FF00}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
